duty_ramp_sequencer: RTL and testbench
======================================

DUTY_RAMP_SEQUENCER -- requirements
Module: duty_ramp_sequencer

Interface
REQ-001 The block SHALL have parameter TICK_DIV_W, default 16, giving the width of the tick prescaler.
REQ-002 The block SHALL have port CLK  input  1  rising-edge clock.
REQ-003 The block SHALL have port RSTB  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port ENABLE  input  1  run request; low forces IDLE.
REQ-005 The block SHALL have port TICK_DIV  input  TICK_DIV_W  clocks per ramp tick minus one.
REQ-006 The block SHALL have port STEP  input  8  duty increment/decrement per tick; a value of 0 SHALL be treated as 1.
REQ-007 The block SHALL have port DUTY_MIN  input  8  lower ramp bound.
REQ-008 The block SHALL have port DUTY_MAX  input  8  upper ramp bound.
REQ-009 The block SHALL have port HOLD_TICKS  input  8  ticks spent at each bound.
REQ-010 The block SHALL have port DUTY_CYCLE  output  8  registered duty value driving the downstream PWM duty input.
REQ-011 The block SHALL have port RAMP_DIR  output  1  registered direction: 1 during UP/HOLD_HI, 0 otherwise.
REQ-012 The block SHALL have port CYCLE_DONE  output  1  registered one-clock pulse marking completion of a full ramp cycle.

Function
REQ-013 A prescaler SHALL count 0..TICK_DIV and assert an internal tick on the clock in which it equals TICK_DIV, then wrap to 0; TICK_DIV=0 SHALL produce a tick every clock.
REQ-014 The state machine SHALL have states IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
REQ-015 In IDLE, while ENABLE=1, the next clock SHALL load DUTY_CYCLE=DUTY_MIN, clear the prescaler and hold counter, and enter UP.
REQ-016 ENABLE=0 in any state SHALL return to IDLE on the next clock with DUTY_CYCLE=0, RAMP_DIR=0, the prescaler cleared, and no CYCLE_DONE.
REQ-017 In UP on a tick, the block SHALL compute a 9-bit sum DUTY_CYCLE+STEP; if the sum is >= DUTY_MAX, it SHALL set DUTY_CYCLE=DUTY_MAX and enter HOLD_HI; otherwise it SHALL set DUTY_CYCLE to the sum.
REQ-018 In DOWN on a tick, the block SHALL compute a 9-bit signed DUTY_CYCLE-STEP; if the result is <= DUTY_MIN, it SHALL set DUTY_CYCLE=DUTY_MIN, enter HOLD_LO, and assert CYCLE_DONE for that one clock; otherwise it SHALL set DUTY_CYCLE to the difference.
REQ-019 In HOLD_HI/HOLD_LO, the hold counter SHALL increment on each tick, and the block SHALL leave for DOWN/UP on the tick at which the count reaches HOLD_TICKS; HOLD_TICKS=0 SHALL leave on the first tick.
REQ-020 DUTY_CYCLE SHALL never wrap past 255 or below 0, and SHALL remain within [DUTY_MIN, DUTY_MAX] in every non-IDLE state.
REQ-021 If DUTY_MIN >= DUTY_MAX in any non-IDLE state, the block SHALL drive DUTY_CYCLE=DUTY_MIN, remain in its current state, and never assert CYCLE_DONE.
REQ-022 Bound, step and divider inputs SHALL be sampled live on each tick; a change mid-ramp SHALL take effect at the next tick without restarting.
REQ-023 State, DUTY_CYCLE and RAMP_DIR SHALL change only on ticks, except on IDLE entry or exit.

Reset
REQ-024 With RSTB=0 at a rising CLK edge, the block SHALL enter IDLE with DUTY_CYCLE=0, RAMP_DIR=0, CYCLE_DONE=0, and the prescaler and hold counter at 0.
REQ-025 Reset SHALL take priority over ENABLE, and a reset mid-ramp SHALL abort the ramp with no CYCLE_DONE pulse.

Configuration
REQ-026 Macro DUTY_RAMP_HOLD_EN SHALL control the hold states.
REQ-027 With DUTY_RAMP_HOLD_EN defined, HOLD_HI/HOLD_LO and HOLD_TICKS SHALL behave per REQ-019.
REQ-028 With DUTY_RAMP_HOLD_EN undefined, UP SHALL go directly to DOWN and DOWN directly to UP at the bounds, HOLD_TICKS SHALL be ignored, and CYCLE_DONE SHALL pulse on the DOWN->UP transition.

Verification
REQ-029 Reset: hold RSTB=0 for 3 clocks with ENABLE=1 -> DUTY_CYCLE=0, RAMP_DIR=0, CYCLE_DONE=0 throughout.
REQ-030 Basic ramp: TICK_DIV=3, STEP=64, MIN=0, MAX=255, HOLD=1, ENABLE=1 -> DUTY sequence 0,64,128,192,255(hold),191,127,63,0 with changes every 4 clocks, and CYCLE_DONE one clock at 0.
REQ-031 Clamp: STEP=0, MIN=250, MAX=253, TICK_DIV=0 -> sequence 250,251,252,253,252,251,250, never above 253.
REQ-032 Abort: deassert ENABLE mid-UP at DUTY=128 -> DUTY=0 and IDLE next clock; reassert -> restart at DUTY_MIN.
REQ-033 Degenerate: MIN=100, MAX=100 -> DUTY stays 100 and CYCLE_DONE stays 0 for 1000 clocks.
REQ-034 Hold build: compile with and without DUTY_RAMP_HOLD_EN, HOLD=5 -> with the macro, 6 ticks at each bound; without it, direction reverses on the tick after reaching the bound.

Source files
------------

// File: rtl/duty_ramp_sequencer.sv
// Ticked triangular duty-cycle ramp between live DUTY_MIN/DUTY_MAX bounds.
// Define DUTY_RAMP_HOLD_EN to dwell at each bound for HOLD_TICKS+1 ticks.
module duty_ramp_sequencer #(
  parameter int unsigned TICK_DIV_W = 16
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  ENABLE,
  input  logic [TICK_DIV_W-1:0] TICK_DIV,
  input  logic [7:0]            STEP,
  input  logic [7:0]            DUTY_MIN,
  input  logic [7:0]            DUTY_MAX,
  input  logic [7:0]            HOLD_TICKS,
  output logic [7:0]            DUTY_CYCLE,
  output logic                  RAMP_DIR,
  output logic                  CYCLE_DONE
);

  typedef enum logic [2:0] {StIdle, StUp, StHoldHi, StDown, StHoldLo} state_e;

`ifdef DUTY_RAMP_HOLD_EN
  localparam state_e UpExitSt   = StHoldHi;
  localparam state_e DownExitSt = StHoldLo;
`else
  localparam state_e UpExitSt   = StDown;
  localparam state_e DownExitSt = StUp;
`endif

  state_e                state_q, state_d;
  logic [TICK_DIV_W-1:0] div_q, div_d;
  logic [7:0]            duty_q, duty_d;
  logic                  dir_q, dir_d;
  logic                  done_q, done_d;

  logic       tick;
  logic       degenerate;
  logic [7:0] step_eff;
  logic [8:0] sum_up;
  logic [8:0] diff_dn;

  // >= rather than == so a divider lowered below the running count still wraps promptly
  assign tick       = (div_q >= TICK_DIV);
  assign degenerate = (DUTY_MIN >= DUTY_MAX);
  assign step_eff   = (STEP == 8'd0) ? 8'd1 : STEP;
  assign sum_up     = {1'b0, duty_q} + {1'b0, step_eff};
  assign diff_dn    = {1'b0, duty_q} - {1'b0, step_eff};

`ifdef DUTY_RAMP_HOLD_EN
  logic [7:0] hold_q, hold_d;
  logic [7:0] duty_clamp;

  always_comb begin
    duty_clamp = duty_q;
    if (duty_q < DUTY_MIN) begin
      duty_clamp = DUTY_MIN;
    end else if (duty_q > DUTY_MAX) begin
      duty_clamp = DUTY_MAX;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_hold_ticks;
  assign unused_hold_ticks = ^HOLD_TICKS;
`endif

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    duty_d  = duty_q;
    done_d  = 1'b0;
`ifdef DUTY_RAMP_HOLD_EN
    hold_d  = hold_q;
`endif
    if (!ENABLE) begin
      state_d = StIdle;
      div_d   = '0;
      duty_d  = '0;
`ifdef DUTY_RAMP_HOLD_EN
      hold_d  = '0;
`endif
    end else if (state_q == StIdle) begin
      state_d = StUp;
      div_d   = '0;
      duty_d  = DUTY_MIN;
`ifdef DUTY_RAMP_HOLD_EN
      hold_d  = '0;
`endif
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        if (degenerate) begin
          duty_d = DUTY_MIN;
        end else begin
          unique case (state_q)
            StUp: begin
              if (sum_up >= {1'b0, DUTY_MAX}) begin
                duty_d  = DUTY_MAX;
                state_d = UpExitSt;
`ifdef DUTY_RAMP_HOLD_EN
                hold_d  = '0;
`endif
              end else if (sum_up[7:0] < DUTY_MIN) begin
                duty_d = DUTY_MIN;
              end else begin
                duty_d = sum_up[7:0];
              end
            end
            StDown: begin
              // diff_dn[8] set means the subtraction went below zero
              if (diff_dn[8] || (diff_dn[7:0] <= DUTY_MIN)) begin
                duty_d  = DUTY_MIN;
                state_d = DownExitSt;
                done_d  = 1'b1;
`ifdef DUTY_RAMP_HOLD_EN
                hold_d  = '0;
`endif
              end else if (diff_dn[7:0] > DUTY_MAX) begin
                duty_d = DUTY_MAX;
              end else begin
                duty_d = diff_dn[7:0];
              end
            end
`ifdef DUTY_RAMP_HOLD_EN
            StHoldHi, StHoldLo: begin
              duty_d = duty_clamp;
              if (hold_q >= HOLD_TICKS) begin
                state_d = (state_q == StHoldHi) ? StDown : StUp;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + 8'd1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
    end
    dir_d = (state_d == StUp) || (state_d == StHoldHi);
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state_q <= StIdle;
      div_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign DUTY_CYCLE = duty_q;
  assign RAMP_DIR   = dir_q;
  assign CYCLE_DONE = done_q;

endmodule

// File: tb/tb_duty_ramp_sequencer.sv
// Bench for duty_ramp_sequencer: directed scenarios plus randomized traffic
// against a tick-level arithmetic model of the ramp.
module tb_duty_ramp_sequencer;

`ifdef DUTY_RAMP_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic        clk;
  logic        rstb;
  logic        enable;
  logic [15:0] tick_div;
  logic [7:0]  step;
  logic [7:0]  duty_min;
  logic [7:0]  duty_max;
  logic [7:0]  hold_ticks;
  logic [7:0]  duty;
  logic        dir;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: direction as +1/-1 (0 = idle), clocks since ramp start, dwell countdown
  int m_dirn = 0;
  int m_duty = 0;
  int m_run = 0;
  bit m_holding = 1'b0;
  int m_hold_left = 0;
  bit m_done = 1'b0;

  int cap_q[$];

  duty_ramp_sequencer #(
    .TICK_DIV_W(16)
  ) u_dut (
    .CLK       (clk),
    .RSTB      (rstb),
    .ENABLE    (enable),
    .TICK_DIV  (tick_div),
    .STEP      (step),
    .DUTY_MIN  (duty_min),
    .DUTY_MAX  (duty_max),
    .HOLD_TICKS(hold_ticks),
    .DUTY_CYCLE(duty),
    .RAMP_DIR  (dir),
    .CYCLE_DONE(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic reach_bound();
    if (HoldEn) begin
      m_holding   = 1'b1;
      m_hold_left = int'(hold_ticks);
    end else begin
      m_dirn = -m_dirn;
    end
  endtask

  // Advance the model by one clock using the inputs that the coming edge samples
  task automatic model_clock();
    int lo, hi, stp, v;
    m_done = 1'b0;
    if (!rstb || !enable) begin
      m_dirn    = 0;
      m_duty    = 0;
      m_holding = 1'b0;
    end else if (m_dirn == 0) begin
      m_dirn    = 1;
      m_duty    = int'(duty_min);
      m_run     = 0;
      m_holding = 1'b0;
    end else begin
      m_run++;
      if ((m_run % (int'(tick_div) + 1)) == 0) begin
        lo  = int'(duty_min);
        hi  = int'(duty_max);
        stp = (step == 8'd0) ? 1 : int'(step);
        if (lo >= hi) begin
          m_duty = lo;
        end else if (m_holding) begin
          if (m_hold_left == 0) begin
            m_holding = 1'b0;
            m_dirn    = -m_dirn;
          end else begin
            m_hold_left--;
          end
          m_duty = clamp_int(m_duty, lo, hi);
        end else begin
          v = m_duty + m_dirn * stp;
          if (m_dirn > 0 && v >= hi) begin
            m_duty = hi;
            reach_bound();
          end else if (m_dirn < 0 && v <= lo) begin
            m_duty = lo;
            m_done = 1'b1;
            reach_bound();
          end else begin
            m_duty = clamp_int(v, lo, hi);
          end
        end
      end
    end
  endtask

  task automatic tick_clk();
    model_clock();
    @(posedge clk);
    #1;
    check_eq("duty", int'(duty), m_duty);
    check_eq("dir", int'(dir), (m_dirn > 0) ? 1 : 0);
    check_eq("done", int'(done), int'(m_done));
  endtask

  task automatic capture_until_done(input int budget);
    int prev = -1;
    bit seen = 1'b0;
    cap_q.delete();
    for (int i = 0; i < budget && !seen; i++) begin
      tick_clk();
      if (int'(duty) != prev) begin
        cap_q.push_back(int'(duty));
        prev = int'(duty);
      end
      if (done) seen = 1'b1;
    end
    check_eq("done_within_budget", int'(seen), 1);
  endtask

  task automatic go_idle();
    enable = 1'b0;
    tick_clk();
  endtask

  initial begin
    int exp_basic[9] = '{0, 64, 128, 192, 255, 191, 127, 63, 0};
    int exp_clamp[7] = '{250, 251, 252, 253, 252, 251, 250};
    int got, bad, pulses, cnt;
    bit reached;

    rstb       = 1'b0;
    enable     = 1'b1;
    tick_div   = 16'd3;
    step       = 8'd64;
    duty_min   = 8'd0;
    duty_max   = 8'd255;
    hold_ticks = 8'd1;

    // Reset held with ENABLE high
    for (int i = 0; i < 3; i++) begin
      tick_clk();
      check_eq("rst_duty", int'(duty), 0);
      check_eq("rst_dir", int'(dir), 0);
      check_eq("rst_done", int'(done), 0);
    end
    rstb = 1'b1;
    go_idle();

    // Basic ramp
    enable = 1'b1;
    capture_until_done(200);
    check_eq("basic_len", cap_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : -1;
      check_eq("basic_seq", got, exp_basic[i]);
    end

    // Clamp near the top of the range with STEP=0
    go_idle();
    tick_div = 16'd0;
    step     = 8'd0;
    duty_min = 8'd250;
    duty_max = 8'd253;
    enable   = 1'b1;
    capture_until_done(100);
    check_eq("clamp_len", cap_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      got = (i < cap_q.size()) ? cap_q[i] : -1;
      check_eq("clamp_seq", got, exp_clamp[i]);
    end

    // Abort mid-UP, then restart at a new DUTY_MIN
    go_idle();
    tick_div = 16'd3;
    step     = 8'd64;
    duty_min = 8'd0;
    duty_max = 8'd255;
    enable   = 1'b1;
    reached  = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      tick_clk();
      if (m_duty == 128) reached = 1'b1;
    end
    check_eq("abort_reach128", int'(reached), 1);
    enable = 1'b0;
    tick_clk();
    check_eq("abort_duty", int'(duty), 0);
    check_eq("abort_dir", int'(dir), 0);
    duty_min = 8'd10;
    enable   = 1'b1;
    tick_clk();
    check_eq("restart_duty", int'(duty), 10);
    check_eq("restart_dir", int'(dir), 1);

    // Degenerate bounds
    go_idle();
    tick_div = 16'd0;
    duty_min = 8'd100;
    duty_max = 8'd100;
    enable   = 1'b1;
    tick_clk();
    bad    = 0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick_clk();
      if (duty != 8'd100) bad++;
      if (done) pulses++;
    end
    check_eq("degen_off_value", bad, 0);
    check_eq("degen_done_pulses", pulses, 0);

    // Dwell at the top bound
    go_idle();
    tick_div   = 16'd0;
    step       = 8'd255;
    duty_min   = 8'd0;
    duty_max   = 8'd255;
    hold_ticks = 8'd5;
    enable     = 1'b1;
    tick_clk();
    tick_clk();
    check_eq("hold_top", int'(duty), 255);
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      tick_clk();
      if (duty != 8'd255) break;
      cnt++;
    end
    check_eq("hold_top_clocks", cnt, HoldEn ? 7 : 1);

    // Randomized traffic with live bound/step changes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 2) enable = ~enable;
      if (!enable) begin
        tick_div   = 16'($urandom_range(3));
        hold_ticks = 8'($urandom_range(3));
      end
      if ($urandom_range(99) < 5) begin
        step     = 8'($urandom_range(80));
        duty_min = 8'($urandom_range(120));
        duty_max = 8'($urandom_range(255));
      end
      rstb = ($urandom_range(199) != 0);
      tick_clk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
